pc_sequencer: RTL
=================

# pc_sequencer

Program-counter and control-flow unit fed by the control unit's decoded signals (`jump`, `branch_*`, `ret`). Holds the PC, a latched ALU flag register, and a hardware return-address stack. Resolves calls, returns, and conditional branches each cycle and drives the next fetch address to instruction memory. Emits a one-cycle `flush` when the fetch stream is redirected.

## Interface
Parameters:
- `PC_WIDTH`, 10, instruction address width; the PC wraps modulo 2^PC_WIDTH.
- `STACK_DEPTH`, 8, number of return-address entries (power of two, ≥2).

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `stall`  in  1  freeze PC, stack and `flush` generation.
- `jump`  in  1  call: push PC+1, go to `target`.
- `ret`  in  1  return: pop the stack, go to the popped address.
- `branch_always`  in  1  unconditional branch to `target`, no push.
- `branch_zero`, `branch_negative`, `branch_carry`, `branch_overflow`  in  1 each  branch to `target` if the matching flag is 1.
- `target`  in  PC_WIDTH  branch/call destination (immediate field).
- `flags_we`  in  1  latch `flag_z`, `flag_n`, `flag_c`, `flag_v` this cycle.
- `flag_z`, `flag_n`, `flag_c`, `flag_v`  in  1 each  ALU result flags.
- `pc`  out  PC_WIDTH  current fetch address (registered).
- `flush`  out  1  registered; high for exactly one cycle after a taken redirect.
- `stack_depth`  out  clog2(STACK_DEPTH)+1  current number of valid stack entries.
- `stack_overflow`  out  1  sticky; push attempted while full.
- `stack_underflow`  out  1  sticky; pop attempted while empty.

## Operation
- Reset (`rst`=0 at an edge): `pc`=0, stack pointer=0, `stack_depth`=0, flag register=0000, `flush`=0, both error bits=0. Reset overrides `stall` and every control input.
- Control inputs describe the instruction at the current `pc`. Priority when several are high: `ret` > `jump` > `branch_always` > conditional branches. Lower-priority requests are ignored.
- Conditional taken = OR of (`branch_zero`&Z, `branch_negative`&N, `branch_carry`&C, `branch_overflow`&V). Z/N/C/V are the flag values in effect this cycle (see Configuration).
- Next PC:
  - `ret`, stack non-empty: pop; next `pc` = popped address; `stack_depth`−1.
  - `ret`, stack empty: set `stack_underflow`; treat as a NOP (next `pc` = `pc`+1); no redirect.
  - `jump`, stack not full: push `pc`+1 (mod 2^PC_WIDTH); next `pc` = `target`; `stack_depth`+1.
  - `jump`, stack full: set `stack_overflow`; discard the push; next `pc` = `target` (the call is still taken).
  - Taken branch: next `pc` = `target`. Otherwise next `pc` = `pc`+1, wrapping from 2^PC_WIDTH−1 to 0.
- A redirect is any taken `ret`, `jump` or branch. `flush`=1 in the cycle after a redirect, including when `target` equals `pc`+1.
- `stall`=1: PC, stack, `stack_depth`, error bits hold; `flush`=0 next cycle; no control input takes effect. Flags still latch when `flags_we`=1.
- The flag register loads all four flags when `flags_we`=1 and otherwise holds.
- The error bits clear only on reset.

## Timing
- Single-cycle resolution: control inputs sampled at edge N → new `pc` valid after edge N, `flush` high from edge N until edge N+1.
- Stack push/pop and PC update commit at the same edge. A `ret` in the cycle immediately after a `jump` pops the address pushed by that `jump`.
- Back-to-back redirects keep `flush` high for consecutive cycles, one cycle per redirect.
- When `stall` deasserts, the control inputs present in that cycle are acted on at the next edge.

## Configuration
- `PC_SEQ_FLAG_FWD_EN` defined: when `flags_we`=1, branch evaluation in the same cycle uses the incoming `flag_*` values (bypass). Otherwise it uses the registered flags.
- `PC_SEQ_FLAG_FWD_EN` undefined: branches always use the registered flags. A branch in the same cycle as `flags_we` sees the previous flags.

## Test plan
- Reset then free-run, 1030 cycles with PC_WIDTH=10 → `pc` reaches 1023, wraps to 0, `flush` never asserts.
- `pc`=5: `jump` with `target`=40 → `pc`=40, `flush` pulses once, `stack_depth`=1. Then `ret` → `pc`=6, `stack_depth`=0.
- 9 nested `jump`s with STACK_DEPTH=8 → 9th sets `stack_overflow`, `pc`=its `target`, `stack_depth` stays 8. Then `ret` on an empty stack after 8 pops → `stack_underflow`=1, `pc` increments.
- `flags_we`=1 with Z=1 while `branch_zero`=1, `target`=100 → with the macro defined the branch is taken (`pc`=100); without it the branch is not taken (`pc`+1). The next-cycle `branch_zero` is taken in both builds.
- `ret`, `jump` and `branch_always` high together with a non-empty stack → pop wins; `stack_depth` decrements; no push.
- `stall`=1 for 3 cycles with `jump` held, then `rst`=0 mid-stall → `pc` holds during the stall, then `pc`=0, `stack_depth`=0, error bits 0 after the reset edge.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter, latched ALU flags and a hardware return-address
// stack. Each cycle resolves ret/call/branch requests, updates the fetch address
// and pulses flush for one cycle after any redirect of the fetch stream.
//
// Optional feature: define PC_SEQ_FLAG_FWD_EN to let a branch see the flags
// being written in the same cycle (flags_we=1). Without it, branches always see
// the registered flags.
module pc_sequencer #(
  parameter int PC_WIDTH    = 10,
  parameter int STACK_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,              // synchronous, active-low
  input  logic                         stall,
  input  logic                         jump,
  input  logic                         ret,
  input  logic                         branch_always,
  input  logic                         branch_zero,
  input  logic                         branch_negative,
  input  logic                         branch_carry,
  input  logic                         branch_overflow,
  input  logic [PC_WIDTH-1:0]          target,
  input  logic                         flags_we,
  input  logic                         flag_z,
  input  logic                         flag_n,
  input  logic                         flag_c,
  input  logic                         flag_v,
  output logic [PC_WIDTH-1:0]          pc,
  output logic                         flush,
  output logic [$clog2(STACK_DEPTH):0] stack_depth,
  output logic                         stack_overflow,
  output logic                         stack_underflow
);

  localparam int SP_W    = $clog2(STACK_DEPTH);
  localparam int DEPTH_W = SP_W + 1;
  localparam logic [DEPTH_W-1:0]  DEPTH_FULL = DEPTH_W'(STACK_DEPTH);
  localparam logic [DEPTH_W-1:0]  DEPTH_ONE  = DEPTH_W'(1);
  localparam logic [PC_WIDTH-1:0] PC_ONE     = PC_WIDTH'(1);
  localparam logic [SP_W-1:0]     SP_ONE     = SP_W'(1);

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

  // What this cycle does to PC and stack, after priority resolution.
  typedef enum logic [2:0] {
    ACT_HOLD,        // stalled: nothing but the flag register moves
    ACT_SEQ,         // fall through to pc+1
    ACT_POP,         // return to the top-of-stack address
    ACT_POP_EMPTY,   // return with nothing to pop: flag it, fall through
    ACT_CALL,        // push pc+1, go to target
    ACT_CALL_FULL,   // call with a full stack: flag it, still go to target
    ACT_BRANCH       // taken branch to target
  } action_e;

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [DEPTH_W-1:0]  depth_q, depth_d;
  flags_t              flags_q, flags_d;
  logic                flush_q, flush_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;

  logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];

  flags_t              flags_in;
  flags_t              eval_flags;
  logic                cond_taken;
  logic                stack_empty;
  logic                stack_full;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] top_addr;
  logic [SP_W-1:0]     push_idx;
  logic [SP_W-1:0]     pop_idx;
  logic                push_en;
  action_e             action;

  assign flags_in    = '{z: flag_z, n: flag_n, c: flag_c, v: flag_v};
  assign stack_empty = (depth_q == '0);
  assign stack_full  = (depth_q == DEPTH_FULL);
  assign pc_inc      = pc_q + PC_ONE;                  // wraps naturally at 2^PC_WIDTH
  assign push_idx    = depth_q[SP_W-1:0];              // full stack never pushes, so index stays in range
  assign pop_idx     = depth_q[SP_W-1:0] - SP_ONE;     // depth==STACK_DEPTH wraps to the last entry
  assign top_addr    = stack_q[pop_idx];

`ifdef PC_SEQ_FLAG_FWD_EN
  assign eval_flags = flags_we ? flags_in : flags_q;
`else
  assign eval_flags = flags_q;
`endif

  assign cond_taken = (branch_zero     & eval_flags.z) |
                      (branch_negative & eval_flags.n) |
                      (branch_carry    & eval_flags.c) |
                      (branch_overflow & eval_flags.v);

  // Priority decode: stall, then ret > jump > branch_always > conditional.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
    action = ACT_SEQ;
    if (stall) begin
      action = ACT_HOLD;
    end else if (ret) begin
      action = stack_empty ? ACT_POP_EMPTY : ACT_POP;
    end else if (jump) begin
      action = stack_full ? ACT_CALL_FULL : ACT_CALL;
    end else if (branch_always || cond_taken) begin
      action = ACT_BRANCH;
    end
  end

  // Next-state computation for PC, depth, flush, error bits and flags.
  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    flush_d = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_en = 1'b0;
    flags_d = flags_we ? flags_in : flags_q;   // flags latch even while stalled
    case (action)
      ACT_HOLD: ;
      ACT_SEQ: pc_d = pc_inc;
      ACT_POP: begin
        pc_d    = top_addr;
        depth_d = depth_q - DEPTH_ONE;
        flush_d = 1'b1;
      end
      ACT_POP_EMPTY: begin
        pc_d  = pc_inc;
        unf_d = 1'b1;
      end
      ACT_CALL: begin
        pc_d    = target;
        depth_d = depth_q + DEPTH_ONE;
        flush_d = 1'b1;
        push_en = 1'b1;
      end
      ACT_CALL_FULL: begin
        pc_d    = target;
        ovf_d   = 1'b1;
        flush_d = 1'b1;
      end
      ACT_BRANCH: begin
        pc_d    = target;
        flush_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (!rst) begin
      pc_q    <= '0;
      depth_q <= '0;
      flags_q <= '0;
      flush_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      flags_q <= flags_d;
      flush_q <= flush_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Return-address storage: written on a successful push only.
  always_ff @(posedge clk) begin
    // NOTE: the stack array is not reset; entries above depth_q are never read, so clearing them would only cost reset fan-out.
    if (rst && push_en) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  assign pc              = pc_q;
  assign flush           = flush_q;
  assign stack_depth     = depth_q;
  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;

endmodule
